// File: rtl/hamm_pkg.sv
// Shared Hamming(38,32) definitions: widths, parity positions and the data-to-position map.
// Used by the receiver (hamm_rcv) and by any matching encoder.
package hamm_pkg;

    localparam int unsigned Nbits_32  = 32;
    localparam int unsigned Nbits_ham = 38;
    localparam int unsigned N_PAR     = 6;
    localparam int unsigned SYN_W     = 6;
    localparam int unsigned CIDX_W    = $clog2(Nbits_ham);
    localparam int unsigned DIDX_W    = $clog2(Nbits_32);

    // Code positions are 1-based; position k lives at bit k-1 of the coded word.
    localparam int unsigned PAR_POS [N_PAR] = '{1, 2, 4, 8, 16, 32};

    localparam int unsigned DATA_POS [Nbits_32] = '{
         3,  5,  6,  7,  9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21,
        22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 33, 34, 35, 36, 37, 38
    };

    typedef logic [Nbits_ham-1:0] code_t;
    typedef logic [Nbits_32-1:0]  data_t;

    function automatic data_t hamm_extract(input code_t w);
        data_t d;
        d = '0;
        for (int unsigned i = 0; i < Nbits_32; i++) begin
            d[DIDX_W'(i)] = w[CIDX_W'(DATA_POS[i] - 1)];
        end
        return d;
    endfunction

    // Each parity bit covers the data positions whose index has that parity's bit set.
    function automatic code_t hamm_encode(input data_t d);
        code_t w;
        logic  par;
        w = '0;
        for (int unsigned i = 0; i < Nbits_32; i++) begin
            w[CIDX_W'(DATA_POS[i] - 1)] = d[DIDX_W'(i)];
        end
        for (int unsigned j = 0; j < N_PAR; j++) begin
            par = 1'b0;
            for (int unsigned i = 0; i < Nbits_32; i++) begin
                if (((DATA_POS[i] >> j) & 1) != 0) begin
                    par = par ^ d[DIDX_W'(i)];
                end
            end
            w[CIDX_W'(PAR_POS[j] - 1)] = par;
        end
        return w;
    endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// Combinational Hamming syndrome: XOR of the 1-based positions of all set bits.
module hamm_syndrome
    import hamm_pkg::*;
(
    input  logic [Nbits_ham-1:0] word_i,
    output logic [SYN_W-1:0]     syn_o
);

    always_comb begin
        syn_o = '0;
        for (int unsigned k = 1; k <= Nbits_ham; k++) begin
            if (word_i[CIDX_W'(k - 1)]) begin
                syn_o = syn_o ^ SYN_W'(k);
            end
        end
    end

endmodule

// File: rtl/hamm_rcv.sv
// Two-stage Hamming(38,32) receiver with ready/valid flow control and error flags.
// Optional saturating error counters are built when HAMM_RCV_ERRCNT_EN is defined.
module hamm_rcv #(
    parameter int unsigned Nbits_32  = hamm_pkg::Nbits_32,
    parameter int unsigned Nbits_ham = hamm_pkg::Nbits_ham,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [Nbits_ham-1:0] data_ham_out,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [Nbits_32-1:0]  data_output,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 single_err,
    output logic                 uncorr_err,
    input  logic                 cnt_clear,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);
    import hamm_pkg::*;

    logic [SYN_W-1:0]     syn_c;
    logic                 s1_v_q, s1_v_d;
    logic [Nbits_ham-1:0] s1_word_q, s1_word_d;
    logic [SYN_W-1:0]     s1_syn_q, s1_syn_d;
    logic                 s2_v_q, s2_v_d;
    logic [Nbits_32-1:0]  s2_data_q, s2_data_d;
    logic                 s2_single_q, s2_single_d;
    logic                 s2_uncorr_q, s2_uncorr_d;
    logic                 s2_stall_c, accept_c, in_range_c, unused_par_c;
    logic [Nbits_ham-1:0] fixed_c;

    hamm_syndrome u_syn (
        .word_i (data_ham_out),
        .syn_o  (syn_c)
    );

    always_comb begin
        s2_stall_c = s2_v_q & ~out_ready;
        in_ready   = reset & ~(s1_v_q & s2_stall_c);
        accept_c   = in_valid & in_ready;
    end

    // Single-bit correction; the syndrome names the 1-based position to flip.
    always_comb begin
        fixed_c    = s1_word_q;
        in_range_c = (s1_syn_q != '0) && (s1_syn_q <= SYN_W'(Nbits_ham));
        if (in_range_c) begin
            fixed_c[s1_syn_q - SYN_W'(1)] = ~s1_word_q[s1_syn_q - SYN_W'(1)];
        end
        unused_par_c = 1'b0;
        for (int unsigned j = 0; j < N_PAR; j++) begin
            unused_par_c = unused_par_c ^ fixed_c[CIDX_W'(PAR_POS[j] - 1)];
        end
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_word_d   = s1_word_q;
        s1_syn_d    = s1_syn_q;
        s2_v_d      = s2_v_q;
        s2_data_d   = s2_data_q;
        s2_single_d = s2_single_q;
        s2_uncorr_d = s2_uncorr_q;
        // Stage 2 advances whenever it is not holding a word the sink refused.
        if (!s2_stall_c) begin
            s2_v_d      = s1_v_q;
            s2_single_d = s1_v_q & in_range_c;
            s2_uncorr_d = s1_v_q & (s1_syn_q > SYN_W'(Nbits_ham));
            if (s1_v_q) begin
                s2_data_d = Nbits_32'(hamm_extract(fixed_c));
            end
            s1_v_d = 1'b0;
        end
        if (accept_c) begin
            s1_v_d    = 1'b1;
            s1_word_d = data_ham_out;
            s1_syn_d  = syn_c;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            s1_v_q      <= 1'b0;
            s1_word_q   <= '0;
            s1_syn_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_data_q   <= '0;
            s2_single_q <= 1'b0;
            s2_uncorr_q <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_word_q   <= s1_word_d;
            s1_syn_q    <= s1_syn_d;
            s2_v_q      <= s2_v_d;
            s2_data_q   <= s2_data_d;
            s2_single_q <= s2_single_d;
            s2_uncorr_q <= s2_uncorr_d;
        end
    end

    assign data_output = s2_data_q;
    assign out_valid   = s2_v_q;
    assign single_err  = s2_single_q;
    assign uncorr_err  = s2_uncorr_q;

`ifdef HAMM_RCV_ERRCNT_EN
    logic             xfer_c;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_comb begin
        xfer_c       = s2_v_q & out_ready;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clear) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (xfer_c) begin
            if (s2_single_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (s2_uncorr_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`else
    logic unused_cnt_c;
    assign unused_cnt_c = cnt_clear;
    assign corr_cnt     = '0;
    assign uncorr_cnt   = '0;
`endif

endmodule

// File: tb/tb_hamm_rcv.sv
// Directed bench for hamm_rcv: decode/correct vectors, backpressure, reset flush, counters.
module tb_hamm_rcv;

`ifdef HAMM_RCV_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        CLK;
    logic        reset;
    logic [37:0] data_ham_out;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_output;
    logic        out_valid;
    logic        out_ready;
    logic        single_err;
    logic        uncorr_err;
    logic        cnt_clear;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    int total = 0;
    int bad   = 0;

    hamm_rcv dut (
        .CLK          (CLK),
        .reset        (reset),
        .data_ham_out (data_ham_out),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_output  (data_output),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .single_err   (single_err),
        .uncorr_err   (uncorr_err),
        .cnt_clear    (cnt_clear),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Independent encoder: data fills non-power-of-two positions; parity p covers k with bit p set.
    function automatic logic [37:0] enc(input logic [31:0] d);
        logic [37:0] w;
        logic        par;
        int          j;
        w = '0;
        j = 0;
        for (int k = 1; k <= 38; k++) begin
            if ((k & (k - 1)) != 0) begin
                w[6'(k - 1)] = d[5'(j)];
                j++;
            end
        end
        for (int p = 0; p < 6; p++) begin
            par = 1'b0;
            for (int k = 1; k <= 38; k++) begin
                if ((((k >> p) & 1) != 0) && ((k & (k - 1)) != 0)) par = par ^ w[6'(k - 1)];
            end
            w[6'((1 << p) - 1)] = par;
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    typedef struct {
        logic [31:0] d;
        logic [37:0] flip;
        logic [31:0] ed;
        logic        es;
        logic        eu;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] exp_corr;
    logic [15:0] exp_uncorr;
    logic [37:0] err_word;

    initial begin
        vecs[0] = '{32'hDEADBEEF, 38'h0,                     32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1] = '{32'h00000001, 38'h1 << 2,                32'h00000001, 1'b1, 1'b0};
        vecs[2] = '{32'h12345678, (38'h1 << 37) | 38'h1,     32'h92345678, 1'b0, 1'b1};
        vecs[3] = '{32'hCAFEF00D, 38'h1 << 15,               32'hCAFEF00D, 1'b1, 1'b0};
        vecs[4] = '{32'h80000000, 38'h1 << 37,               32'h80000000, 1'b1, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, (38'h1 << 31) | (38'h1 << 30), 32'hFDFFFFFF, 1'b0, 1'b1};
        exp_corr     = '0;
        exp_uncorr   = '0;
        reset        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        cnt_clear    = 1'b0;
        data_ham_out = '0;

        repeat (3) tick();
        chk("rst_in_ready",  in_ready,    0);
        chk("rst_out_valid", out_valid,   0);
        chk("rst_data",      data_output, 0);
        chk("rst_single",    single_err,  0);
        chk("rst_uncorr",    uncorr_err,  0);
        chk("rst_corr_cnt",  corr_cnt,    0);
        chk("rst_uncorr_cnt", uncorr_cnt, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Single-word vectors: two-cycle latency, correction and flags.
        for (int i = 0; i < 6; i++) begin
            data_ham_out = enc(vecs[i].d) ^ vecs[i].flip;
            in_valid     = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_early_valid", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_data", i),      data_output, vecs[i].ed);
            chk($sformatf("v%0d_single", i),    single_err, vecs[i].es);
            chk($sformatf("v%0d_uncorr", i),    uncorr_err, vecs[i].eu);
            if (CNT_EN && vecs[i].es) exp_corr++;
            if (CNT_EN && vecs[i].eu) exp_uncorr++;
            tick();
            chk($sformatf("v%0d_drained", i),    out_valid, 0);
            chk($sformatf("v%0d_flag_idle", i),  {single_err, uncorr_err}, 0);
            chk($sformatf("v%0d_corr_cnt", i),   corr_cnt, exp_corr);
            chk($sformatf("v%0d_uncorr_cnt", i), uncorr_cnt, exp_uncorr);
        end

        // Backpressure: three back-to-back words, sink stalled for four cycles.
        out_ready    = 1'b0;
        data_ham_out = enc(32'hA5A5A5A5);
        in_valid     = 1'b1;
        #1 chk("bp_rdy_a", in_ready, 1);
        tick();
        data_ham_out = enc(32'h0F0F0F0F);
        #1 chk("bp_rdy_b", in_ready, 1);
        tick();
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data_a", data_output, 32'hA5A5A5A5);
        data_ham_out = enc(32'h13579BDF);
        #1 chk("bp_rdy_c_low", in_ready, 0);
        tick();
        tick();
        chk("bp_still_low", in_ready, 0);
        chk("bp_still_a", data_output, 32'hA5A5A5A5);
        out_ready = 1'b1;
        #1 chk("bp_rdy_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_b_valid", out_valid, 1);
        chk("bp_out_b", data_output, 32'h0F0F0F0F);
        tick();
        chk("bp_out_c_valid", out_valid, 1);
        chk("bp_out_c", data_output, 32'h13579BDF);
        tick();
        chk("bp_empty", out_valid, 0);

        // Reset with two words in flight flushes everything.
        out_ready    = 1'b0;
        data_ham_out = enc(32'h11111111);
        in_valid     = 1'b1;
        tick();
        data_ham_out = enc(32'h22222222);
        tick();
        chk("mid_two_in_flight", out_valid, 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("mid_rst_valid",    out_valid,   0);
        chk("mid_rst_data",     data_output, 0);
        chk("mid_rst_in_ready", in_ready,    0);
        chk("mid_rst_flags",    {single_err, uncorr_err}, 0);
        chk("mid_rst_cnts",     {corr_cnt, uncorr_cnt}, 0);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mid_no_pulse1", out_valid, 0);
        tick();
        chk("mid_no_pulse2", out_valid, 0);

        // Saturation: 0xFFFF+2 single-error words streamed at full rate.
        err_word     = enc(32'h00000001) ^ (38'h1 << 2);
        data_ham_out = err_word;
        in_valid     = 1'b1;
        repeat (65537) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("sat_drained",    out_valid, 0);
        chk("sat_corr_cnt",   corr_cnt, CNT_EN ? 16'hFFFF : 16'h0);
        chk("sat_uncorr_cnt", uncorr_cnt, 0);

        // Clear coincides with the transfer of an error word.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_single", single_err, 1);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("clr_corr_cnt", corr_cnt, 0);
        chk("clr_drained",  out_valid, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("after_clr_cnt", corr_cnt, CNT_EN ? 16'h1 : 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
